// File: rtl/memory_game_ctrl_if.sv
// Keyboard event and animator card-lookup port of the memory-match game sequencer.
// key_strobe is a one-cycle valid with no ready: the sequencer samples key_in/key_released/ext on that cycle or drops the event.
interface memory_game_ctrl_if;
  logic       key_strobe;
  logic [7:0] key_in;
  logic       key_released;
  logic       ext;
  logic [3:0] rd_addr;
  logic [2:0] rd_val;

  modport master (output key_strobe, key_in, key_released, ext, rd_addr, input rd_val);
  modport slave  (input key_strobe, key_in, key_released, ext, rd_addr, output rd_val);
endinterface

// File: rtl/memory_game_ctrl.sv
// Memory-match game sequencer for a 4x4 board: cursor, card flips, pair compare,
// reveal timer, move count and win detect, driven by decoded PS/2 make codes.
module memory_game_ctrl #(
  parameter int SHOW_CYCLES = 50_000_000,
  parameter int MOVES_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  memory_game_ctrl_if.slave  kbd,
  output logic [3:0]         cursor,
  output logic [15:0]        face_up,
  output logic [15:0]        matched,
  output logic [MOVES_W-1:0] moves,
  output logic [2:0]         state_o,
  output logic               game_won
);
  localparam int TW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [TW-1:0]      T_LOAD   = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0]      T_ONE    = TW'(1);
  localparam logic [MOVES_W-1:0] MOVE_ONE = MOVES_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_SEL1  = 3'd2,
    S_SEL2  = 3'd3,
    S_CMP   = 3'd4,
    S_SHOW  = 3'd5,
    S_WIN   = 3'd6
  } state_t;

  state_t        state;
  logic [3:0]    seed;
  logic [3:0]    seed_lat;
  logic [3:0]    card_a;
  logic [3:0]    card_b;
  logic [TW-1:0] timer;

  logic key_ok, k_up, k_down, k_left, k_right, k_enter, k_space, k_esc;
  logic [3:0]  cur_nxt;
  logic [15:0] cur_bit;
  logic [15:0] ab_bits;
  logic        pick_ok;
  logic        pair_eq;

  // Pairs come from dropping the low bit after scrambling the index with the seed.
  function automatic logic [2:0] card_val(input logic [3:0] idx, input logic [3:0] s);
    logic [3:0] x;
    x = idx ^ s;
    return x[3:1];
  endfunction

  assign kbd.rd_val = card_val(kbd.rd_addr, seed_lat);
  assign state_o    = state;

  always_comb begin
    key_ok  = kbd.key_strobe && !kbd.key_released;
    k_up    = key_ok &&  kbd.ext && (kbd.key_in == 8'h75);
    k_down  = key_ok &&  kbd.ext && (kbd.key_in == 8'h72);
    k_left  = key_ok &&  kbd.ext && (kbd.key_in == 8'h6B);
    k_right = key_ok &&  kbd.ext && (kbd.key_in == 8'h74);
    k_enter = key_ok && !kbd.ext && (kbd.key_in == 8'h5A);
    k_space = key_ok && !kbd.ext && (kbd.key_in == 8'h29);
    k_esc   = key_ok && !kbd.ext && (kbd.key_in == 8'h76);

    // Up/down wrap through the whole board; left/right stay in the current row.
    cur_nxt = cursor;
    if (k_up)         cur_nxt = cursor - 4'd4;
    else if (k_down)  cur_nxt = cursor + 4'd4;
    else if (k_left)  cur_nxt = {cursor[3:2], cursor[1:0] - 2'd1};
    else if (k_right) cur_nxt = {cursor[3:2], cursor[1:0] + 2'd1};

    cur_bit = 16'd1 << cursor;
    pick_ok = k_space && !face_up[cursor] && !matched[cursor];
    ab_bits = (16'd1 << card_a) | (16'd1 << card_b);
    pair_eq = card_val(card_a, seed_lat) == card_val(card_b, seed_lat);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      seed     <= '0;
      seed_lat <= '0;
      card_a   <= '0;
      card_b   <= '0;
      timer    <= '0;
      cursor   <= '0;
      face_up  <= '0;
      matched  <= '0;
      moves    <= '0;
      game_won <= 1'b0;
    end else begin
      seed <= seed + 4'd1;
      if (k_esc && (state inside {S_SEL1, S_SEL2, S_SHOW, S_WIN})) begin
        state    <= S_START;
        game_won <= 1'b0;
      end else begin
        if (state inside {S_SEL1, S_SEL2, S_SHOW}) cursor <= cur_nxt;
        case (state)
          S_IDLE: if (k_enter) state <= S_START;
          S_START: begin
            seed_lat <= seed;
            face_up  <= '0;
            matched  <= '0;
            moves    <= '0;
            timer    <= '0;
            state    <= S_SEL1;
          end
          S_SEL1: if (pick_ok) begin
            face_up <= face_up | cur_bit;
            card_a  <= cursor;
            state   <= S_SEL2;
          end
          S_SEL2: if (pick_ok) begin
            face_up <= face_up | cur_bit;
            card_b  <= cursor;
            if (moves != '1) moves <= moves + MOVE_ONE;
            state   <= S_CMP;
          end
          S_CMP: begin
            if (pair_eq) begin
              matched <= matched | ab_bits;
              face_up <= face_up & ~ab_bits;
              if ((matched | ab_bits) == 16'hFFFF) begin
                state    <= S_WIN;
                game_won <= 1'b1;
              end else begin
                state <= S_SEL1;
              end
            end else begin
              timer <= T_LOAD;
              state <= S_SHOW;
            end
          end
          S_SHOW: begin
            if (timer == '0) begin
              face_up <= face_up & ~ab_bits;
              state   <= S_SEL1;
            end else begin
              timer <= timer - T_ONE;
            end
          end
          S_WIN: if (k_enter) begin
            state    <= S_START;
            game_won <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_memory_game_ctrl.sv
// Self-checking bench for memory_game_ctrl: directed scenarios plus randomized key
// streams checked against a board-level model of the game rules.
module tb_memory_game_ctrl;
  localparam int SC = 8;
  localparam int MW = 8;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_START = 3'd1, ST_SEL1 = 3'd2,
                         ST_SEL2 = 3'd3, ST_SHOW = 3'd5, ST_WIN = 3'd6;
  localparam logic [7:0] K_UP = 8'h75, K_DOWN = 8'h72, K_LEFT = 8'h6B, K_RIGHT = 8'h74,
                         K_ENTER = 8'h5A, K_SPACE = 8'h29, K_ESC = 8'h76;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [3:0]    cursor;
  logic [15:0]   face_up, matched;
  logic [MW-1:0] moves;
  logic [2:0]    state_o;
  logic          game_won;

  memory_game_ctrl_if kbd();

  memory_game_ctrl #(.SHOW_CYCLES(SC), .MOVES_W(MW)) dut (
    .clk(clk), .reset(reset), .kbd(kbd), .cursor(cursor), .face_up(face_up),
    .matched(matched), .moves(moves), .state_o(state_o), .game_won(game_won)
  );

  always #5 clk = ~clk;

  // Free-running seed as the game defines it: cleared by reset, +1 every clock.
  logic [3:0] seed_m;
  always @(posedge clk or posedge reset) begin
    if (reset) seed_m <= 4'd0;
    else       seed_m <= seed_m + 4'd1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Board model
  logic [2:0]  m_st;
  logic [3:0]  m_cur, m_seed, m_a;
  logic [15:0] m_face, m_match;
  int          m_moves;
  bit          last_mismatch;
  int          last_show, last_show_ok;

  function automatic int card_value(input int i, input int s);
    return (i ^ s) / 2;
  endfunction

  task automatic model_reset();
    m_st = ST_IDLE; m_cur = 0; m_seed = 0; m_a = 0;
    m_face = 0; m_match = 0; m_moves = 0;
  endtask

  // Called just after a falling edge; returns just after a falling edge with the board settled.
  task automatic press(input logic [7:0] code, input logic e, input logic rel);
    bit go;
    int row, col;
    logic [3:0] c;
    go = 0;
    c = m_cur;
    last_mismatch = 0;
    kbd.key_strobe = 1'b1; kbd.key_in = code; kbd.ext = e; kbd.key_released = rel;
    @(posedge clk); @(negedge clk);
    kbd.key_strobe = 1'b0;
    if (!rel && !e && code == K_ESC && m_st != ST_IDLE) go = 1;
    else if (!rel && !e && code == K_ENTER && (m_st == ST_IDLE || m_st == ST_WIN)) go = 1;
    if (go) begin
      m_seed = seed_m; m_face = 0; m_match = 0; m_moves = 0; m_st = ST_SEL1;
    end else if (!rel && (m_st == ST_SEL1 || m_st == ST_SEL2)) begin
      row = c / 4; col = c % 4;
      if (e && code == K_UP)         row = (row + 3) % 4;
      else if (e && code == K_DOWN)  row = (row + 1) % 4;
      else if (e && code == K_LEFT)  col = (col + 3) % 4;
      else if (e && code == K_RIGHT) col = (col + 1) % 4;
      m_cur = 4'(row * 4 + col);
      if (!e && code == K_SPACE && !m_face[c] && !m_match[c]) begin
        m_face[c] = 1'b1;
        if (m_st == ST_SEL1) begin
          m_a = c; m_st = ST_SEL2;
        end else begin
          m_moves = (m_moves == 255) ? 255 : m_moves + 1;
          m_st = ST_SEL1;
          if (card_value(m_a, m_seed) == card_value(c, m_seed)) begin
            m_face[m_a] = 0; m_face[c] = 0; m_match[m_a] = 1; m_match[c] = 1;
            if (m_match == 16'hFFFF) m_st = ST_WIN;
          end else begin
            last_mismatch = 1;
          end
        end
      end
    end
    @(posedge clk); @(negedge clk);
    if (last_mismatch) begin
      last_show = 0; last_show_ok = 0;
      for (int i = 0; i < SC + 4 && state_o == ST_SHOW; i++) begin
        last_show++;
        if (face_up === m_face) last_show_ok++;
        @(negedge clk);
      end
      m_face[m_a] = 0; m_face[c] = 0;
    end
  endtask

  task automatic start_game(input logic [3:0] s);
    for (int i = 0; i < 17 && seed_m != s - 4'd1; i++) @(negedge clk);
    if (m_st == ST_IDLE || m_st == ST_WIN) press(K_ENTER, 1'b0, 1'b0);
    else press(K_ESC, 1'b0, 1'b0);
  endtask

  task automatic goto(input int t);
    for (int i = 0; i < 4 && (m_cur % 4) != (t % 4); i++) press(K_RIGHT, 1'b1, 1'b0);
    for (int i = 0; i < 4 && (m_cur / 4) != (t / 4); i++) press(K_DOWN, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    n_checks++; if (state_o !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", state_o, ST_IDLE); end
    n_checks++; if (cursor !== 4'd0) begin n_fail++; $display("FAIL reset_cursor got %0d want 0", cursor); end
    n_checks++; if (face_up !== 16'h0 || matched !== 16'h0) begin n_fail++; $display("FAIL reset_board got face %h matched %h want 0 0", face_up, matched); end
    n_checks++; if (moves !== 8'd0 || game_won !== 1'b0) begin n_fail++; $display("FAIL reset_moves_won got %0d %b want 0 0", moves, game_won); end
    reset = 1'b0;
    model_reset();
    press(K_LEFT, 1'b1, 1'b0);
    press(K_SPACE, 1'b0, 1'b0);
    n_checks++; if (cursor !== 4'd0 || state_o !== ST_IDLE) begin n_fail++; $display("FAIL idle_frozen got cursor %0d state %0d want 0 %0d", cursor, state_o, ST_IDLE); end
  endtask

  task automatic test_start();
    press(K_ENTER, 1'b0, 1'b0);
    n_checks++; if (state_o !== ST_SEL1) begin n_fail++; $display("FAIL start_state got %0d want %0d", state_o, ST_SEL1); end
    n_checks++; if (face_up !== 16'h0 || moves !== 8'd0 || cursor !== 4'd0) begin n_fail++; $display("FAIL start_board got face %h moves %0d cursor %0d want 0 0 0", face_up, moves, cursor); end
  endtask

  task automatic test_deck();
    for (int i = 0; i < 16; i++) begin
      kbd.rd_addr = 4'(i);
      #1;
      n_checks++;
      if (kbd.rd_val !== 3'(card_value(i, m_seed))) begin
        n_fail++; $display("FAIL deck_value card %0d seed %0d got %0d want %0d", i, m_seed, kbd.rd_val, card_value(i, m_seed));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_cursor();
    press(K_LEFT, 1'b1, 1'b0);
    n_checks++; if (cursor !== 4'd3) begin n_fail++; $display("FAIL cursor_left got %0d want 3", cursor); end
    press(K_UP, 1'b1, 1'b0);
    n_checks++; if (cursor !== 4'd15) begin n_fail++; $display("FAIL cursor_up got %0d want 15", cursor); end
    press(K_RIGHT, 1'b1, 1'b0);
    n_checks++; if (cursor !== 4'd12) begin n_fail++; $display("FAIL cursor_right got %0d want 12", cursor); end
    press(K_DOWN, 1'b1, 1'b0);
    n_checks++; if (cursor !== 4'd0) begin n_fail++; $display("FAIL cursor_down got %0d want 0", cursor); end
    press(K_LEFT, 1'b1, 1'b1);
    press(K_UP, 1'b0, 1'b0);
    n_checks++; if (cursor !== 4'd0) begin n_fail++; $display("FAIL cursor_break_wrongext got %0d want 0", cursor); end
  endtask

  task automatic test_match();
    start_game(4'd0);
    goto(0); press(K_SPACE, 1'b0, 1'b0);
    goto(1); press(K_SPACE, 1'b0, 1'b0);
    n_checks++; if (matched !== 16'h0003 || face_up !== 16'h0) begin n_fail++; $display("FAIL match_board got matched %h face %h want 0003 0000", matched, face_up); end
    n_checks++; if (moves !== 8'd1 || state_o !== ST_SEL1) begin n_fail++; $display("FAIL match_moves got moves %0d state %0d want 1 %0d", moves, state_o, ST_SEL1); end
  endtask

  task automatic test_mismatch();
    start_game(4'd0);
    goto(0); press(K_SPACE, 1'b0, 1'b0);
    goto(2); press(K_SPACE, 1'b0, 1'b0);
    n_checks++; if (last_show !== SC || last_show_ok !== SC) begin n_fail++; $display("FAIL show_time got %0d cycles (%0d with face 0005) want %0d", last_show, last_show_ok, SC); end
    n_checks++; if (face_up !== 16'h0 || matched !== 16'h0 || moves !== 8'd1) begin n_fail++; $display("FAIL show_after got face %h matched %h moves %0d want 0 0 1", face_up, matched, moves); end
  endtask

  task automatic test_reflip();
    start_game(4'd0);
    goto(0); press(K_SPACE, 1'b0, 1'b0);
    press(K_SPACE, 1'b0, 1'b0);
    n_checks++; if (state_o !== ST_SEL2 || moves !== 8'd0 || face_up !== 16'h0001) begin n_fail++; $display("FAIL reflip got state %0d moves %0d face %h want %0d 0 0001", state_o, moves, face_up, ST_SEL2); end
    press(K_ESC, 1'b0, 1'b0);
    n_checks++; if (state_o !== ST_SEL1 || face_up !== 16'h0 || matched !== 16'h0) begin n_fail++; $display("FAIL esc_clear got state %0d face %h matched %h want %0d 0 0", state_o, face_up, matched, ST_SEL1); end
  endtask

  task automatic test_win();
    logic [3:0] cur_before;
    start_game(4'd0);
    for (int p = 0; p < 8; p++) begin
      goto(2 * p);     press(K_SPACE, 1'b0, 1'b0);
      goto(2 * p + 1); press(K_SPACE, 1'b0, 1'b0);
    end
    n_checks++; if (game_won !== 1'b1 || state_o !== ST_WIN) begin n_fail++; $display("FAIL win_flag got won %b state %0d want 1 %0d", game_won, state_o, ST_WIN); end
    n_checks++; if (moves !== 8'd8 || matched !== 16'hFFFF || face_up !== 16'h0) begin n_fail++; $display("FAIL win_board got moves %0d matched %h face %h want 8 ffff 0", moves, matched, face_up); end
    cur_before = m_cur;
    press(K_LEFT, 1'b1, 1'b0);
    n_checks++; if (cursor !== cur_before) begin n_fail++; $display("FAIL win_cursor_frozen got %0d want %0d", cursor, cur_before); end
    kbd.key_strobe = 1'b1; kbd.key_in = K_ENTER; kbd.ext = 1'b0; kbd.key_released = 1'b0;
    @(posedge clk); @(negedge clk);
    kbd.key_strobe = 1'b0;
    m_seed = seed_m;
    n_checks++; if (state_o !== ST_START || game_won !== 1'b0) begin n_fail++; $display("FAIL win_restart got state %0d won %b want %0d 0", state_o, game_won, ST_START); end
    @(posedge clk); @(negedge clk);
    n_checks++; if (state_o !== ST_SEL1 || moves !== 8'd0 || matched !== 16'h0) begin n_fail++; $display("FAIL win_newgame got state %0d moves %0d matched %h want %0d 0 0", state_o, moves, matched, ST_SEL1); end
    m_st = ST_SEL1; m_face = 0; m_match = 0; m_moves = 0;
  endtask

  task automatic test_random();
    logic [7:0] arrows[4];
    logic [7:0] code;
    logic e, rel;
    int pick;
    arrows[0] = K_UP; arrows[1] = K_DOWN; arrows[2] = K_LEFT; arrows[3] = K_RIGHT;
    for (int g = 0; g < 3; g++) begin
      start_game(4'($urandom_range(0, 15)));
      test_deck();
      for (int k = 0; k < 150; k++) begin
        pick = $urandom_range(0, 99);
        rel = 1'b0;
        if (pick < 40)      begin code = K_SPACE; e = 1'b0; end
        else if (pick < 80) begin code = arrows[$urandom_range(0, 3)]; e = 1'b1; end
        else if (pick < 88) begin code = ($urandom_range(0, 1) == 0) ? 8'h1C : K_ENTER; e = 1'b0; end
        else if (pick < 92) begin code = ($urandom_range(0, 1) == 0) ? K_SPACE : K_ESC; e = 1'b1; end
        else if (pick < 98) begin code = K_SPACE; e = 1'b0; rel = 1'b1; end
        else                begin code = K_ESC; e = 1'b0; end
        press(code, e, rel);
        n_checks++; if (cursor !== m_cur) begin n_fail++; $display("FAIL rand_cursor key %0d got %0d want %0d", k, cursor, m_cur); end
        n_checks++; if (face_up !== m_face || matched !== m_match) begin n_fail++; $display("FAIL rand_board key %0d got face %h matched %h want %h %h", k, face_up, matched, m_face, m_match); end
        n_checks++; if (moves !== 8'(m_moves) || state_o !== m_st || game_won !== (m_st == ST_WIN)) begin n_fail++; $display("FAIL rand_state key %0d got moves %0d state %0d won %b want %0d %0d", k, moves, state_o, game_won, m_moves, m_st); end
        if (last_mismatch) begin
          n_checks++; if (last_show !== SC || last_show_ok !== SC) begin n_fail++; $display("FAIL rand_show key %0d got %0d/%0d want %0d", k, last_show, last_show_ok, SC); end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    start_game(4'd0);
    goto(0); press(K_SPACE, 1'b0, 1'b0);
    goto(2);
    kbd.key_strobe = 1'b1; kbd.key_in = K_SPACE; kbd.ext = 1'b0; kbd.key_released = 1'b0;
    @(posedge clk); @(negedge clk);
    kbd.key_strobe = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++; if (state_o !== ST_SHOW) begin n_fail++; $display("FAIL mid_show_entry got %0d want %0d", state_o, ST_SHOW); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (state_o !== ST_IDLE || face_up !== 16'h0 || moves !== 8'd0 || cursor !== 4'd0) begin n_fail++; $display("FAIL async_reset got state %0d face %h moves %0d cursor %0d want %0d 0 0 0", state_o, face_up, moves, cursor, ST_IDLE); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    kbd.key_strobe = 1'b0; kbd.key_in = 8'h00; kbd.key_released = 1'b0; kbd.ext = 1'b0;
    kbd.rd_addr = 4'd0;
    model_reset();
    last_mismatch = 0; last_show = 0; last_show_ok = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_start();
    test_deck();
    test_cursor();
    test_match();
    test_mismatch();
    test_reflip();
    test_win();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
